// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: bit-serial add/subtract using one reused full-adder cell.
// Define SERIAL_SUB_EN to enable subtract; otherwise sub is ignored (add only).
module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [CW-1:0] cnt;
  logic carry, sub_eff, sub_in, accept, last, bx, s, c;
  logic [WIDTH:0] rs;
`ifdef SERIAL_SUB_EN
  logic sub_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sub_q <= 1'b0;
    else if (accept) sub_q <= sub;
  assign sub_eff = sub_q;
  assign sub_in  = sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign sub_eff    = 1'b0;
  assign sub_in     = 1'b0;
`endif
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    accept  = start && state != RUN;
    last    = cnt == CW'(WIDTH - 1);
    bx      = b_sr[0] ^ sub_eff;
    s       = a_sr[0] ^ bx ^ carry;
    c       = (a_sr[0] & bx) | (carry & (a_sr[0] ^ bx));
    rs      = {s, result} >> 1;
    state_n = accept ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        a_sr   <= a;
        b_sr   <= b;
        cnt    <= '0;
        carry  <= sub_in;
        result <= '0;
      end else if (state == RUN) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        result <= rs[WIDTH-1:0];
        carry  <= c;
        cnt    <= cnt + 1'b1;
        if (last) begin
          cout <= c;
          ovf  <= carry ^ c;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb_serial_addsub_ctrl: directed and random checks of serial_addsub_ctrl against
// an arithmetic reference model.
module tb_serial_addsub_ctrl;
  localparam int W = 8;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, sub = 1'b0;
  logic [W-1:0] a = '0, b = '0, result;
  logic busy, done, cout, ovf;
  int checks = 0, failures = 0;

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .sub(sub),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // returns {ovf, cout, result}
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s_in);
    logic s;
    logic [W-1:0] yy;
    logic [W:0] sum;
    logic v;
`ifdef SERIAL_SUB_EN
    s = s_in;
`else
    s = 1'b0 & s_in;
`endif
    yy  = s ? ~y : y;
    sum = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
    v   = (x[W-1] == yy[W-1]) && (sum[W-1] != x[W-1]);
    return {v, sum[W], sum[W-1:0]};
  endfunction

  // called away from a clock edge; start is sampled at the next rising edge
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    start = 1'b1; a = x; b = y; sub = s;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // entered #1 into cycle T+1; leaves #1 into the done cycle after checking it
  task automatic track(input string tag, input logic [W+1:0] exp, input bit poke);
    for (int k = 1; k <= W; k++) begin
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_done_early"}, done, 0);
      if (poke && k == 3) begin start = 1'b1; a = 8'h01; b = 8'h01; end
      if (poke && k == 4) start = 1'b0;
      @(posedge clk); #1;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_off"}, busy, 0);
    chk({tag, "_result"}, result, exp[W-1:0]);
    chk({tag, "_cout"}, cout, exp[W]);
    chk({tag, "_ovf"}, ovf, exp[W+1]);
  endtask

  task automatic op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [W+1:0] e;
    e = model(x, y, s);
    @(negedge clk);
    launch(x, y, s);
    track(tag, e, 1'b0);
    @(posedge clk); #1;
    chk({tag, "_pulse_end"}, done, 0);
    chk({tag, "_hold"}, result, e[W-1:0]);
    chk({tag, "_hold_c"}, cout, e[W]);
  endtask

  initial begin
    logic [W+1:0] e;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk); rst_n = 1'b1;

    op("add5a3c", 8'h5A, 8'h3C, 1'b0);
    chk("add5a3c_exact", {ovf, cout, result}, {1'b1, 1'b0, 8'h96});
    op("addff01", 8'hFF, 8'h01, 1'b0);
    chk("addff01_exact", {ovf, cout, result}, {1'b0, 1'b1, 8'h00});
    op("sub1020", 8'h10, 8'h20, 1'b1);
`ifdef SERIAL_SUB_EN
    chk("sub1020_exact", {ovf, cout, result}, {1'b0, 1'b0, 8'hF0});
`else
    chk("sub1020_exact", {cout, result}, {1'b0, 8'h30});
`endif

    // start pulsed mid-run must be ignored
    @(negedge clk);
    launch(8'h5A, 8'h3C, 1'b0);
    track("poke", model(8'h5A, 8'h3C, 1'b0), 1'b1);
    chk("poke_exact", result, 8'h96);
    @(posedge clk); #1;

    // reset mid-run aborts with no done
    @(negedge clk);
    launch(8'h5A, 8'h3C, 1'b0);
    for (int k = 1; k < 4; k++) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_cout", cout, 0);
    chk("abort_ovf", ovf, 0);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      chk("abort_no_done", done, 0);
      if (k == 2) rst_n = 1'b1;
    end
    op("after_abort", 8'h33, 8'h44, 1'b0);

    // back-to-back: start held in DONE
    e = model(8'h5A, 8'h3C, 1'b0);
    @(negedge clk);
    launch(8'h5A, 8'h3C, 1'b0);
    track("b2b_first", e, 1'b0);
    launch(8'h01, 8'h02, 1'b0);
    track("b2b_second", model(8'h01, 8'h02, 1'b0), 1'b0);
    chk("b2b_exact", result, 8'h03);
    @(posedge clk); #1;

    for (int i = 0; i < 25; i++)
      op("rand", W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1);
  end
endmodule

// File: doc/serial_addsub_ctrl.md
SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 1..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: an operation request, sampled on the rising edge.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A, captured on start acceptance.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B, captured on start acceptance.
REQ-007 The block SHALL have port sub, input, 1 bit: select subtract (1) or add (0), captured on start acceptance.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse, high while in DONE.
REQ-010 The block SHALL have port result, output, WIDTH bits: the sum or difference, updated LSB first.
REQ-011 The block SHALL have port cout, output, 1 bit: the final carry out (for subtract, 1 = no borrow).
REQ-012 The block SHALL have port ovf, output, 1 bit: two's-complement overflow of the completed operation.

Function
REQ-013 The block SHALL compute with one 1-bit full-adder cell reused over WIDTH cycles, with a registered carry between bits; no WIDTH-bit parallel adder is permitted.
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 In IDLE or DONE, start=1 SHALL be accepted and SHALL:
- load the A and B shift registers,
- clear the bit counter,
- set carry = sub_eff,
- clear result,
- move the FSM to RUN.
REQ-016 Each RUN cycle SHALL add bit A[i] + (B[i] XOR sub_eff) + carry, shift the sum bit into result from the MSB side, update carry and increment the counter.
REQ-017 After the WIDTH-th RUN cycle the FSM SHALL go to DONE, and DONE SHALL return to IDLE after one cycle unless start=1.
REQ-018 Latency SHALL be fixed: with start accepted at edge T, busy is high for cycles T+1..T+WIDTH and done is high for cycle T+WIDTH+1.
REQ-019 start asserted during RUN SHALL be ignored, leaving operands, counter and result unaffected.
REQ-020 start asserted in DONE SHALL begin a new operation back-to-back, with done still pulsing that cycle.
REQ-021 cout SHALL be the final carry, and ovf SHALL be the carry into the MSB XOR the carry out of the MSB; both SHALL be registered on entry to DONE.
REQ-022 result, cout and ovf SHALL hold their values from DONE until the next accepted start.
REQ-023 When WIDTH=1, RUN SHALL last exactly one cycle.

Reset
REQ-024 While rst_n=0, the block SHALL immediately hold the FSM in IDLE and hold busy, done, result, cout, ovf, carry and the counter at 0, independent of clk.
REQ-025 Reset asserted mid-RUN SHALL abort the operation, and no done SHALL be produced for it.
REQ-026 After rst_n deasserts, the first rising edge SHALL be able to accept start.

Configuration
REQ-027 The macro SERIAL_SUB_EN SHALL control subtract support: when it is defined, sub_eff = captured sub.
REQ-028 When SERIAL_SUB_EN is undefined, the sub port SHALL remain present but be ignored, with sub_eff = 0 (add only) and no capture register for sub.

Verification
REQ-029 The bench SHALL cover, for WIDTH=8: a=0x5A, b=0x3C, sub=0, start at T -> busy T+1..T+8, done at T+9, result=0x96, cout=0, ovf=1.
REQ-030 The bench SHALL cover: a=0xFF, b=0x01, sub=0 -> result=0x00, cout=1, ovf=0.
REQ-031 The bench SHALL cover, with SERIAL_SUB_EN defined: a=0x10, b=0x20, sub=1 -> result=0xF0, cout=0, ovf=0; with it undefined, the same stimulus -> result=0x30, cout=0.
REQ-032 The bench SHALL cover: start=1 with a=0x01, b=0x01 pulsed at T+3 during a 0x5A+0x3C run -> no restart, done at T+9, result=0x96.
REQ-033 The bench SHALL cover: rst_n low at T+4 of a run -> all outputs 0 immediately, no done pulse, and the next start completes normally.
REQ-034 The bench SHALL cover: start held high in DONE with a=0x01, b=0x02 -> done pulses, busy next cycle, second done 9 cycles later with result=0x03.
